// File: rtl/reg_arb_pkg.sv
// reg_arb_pkg: shared state encoding and width helper for the register write arbiter
package reg_arb_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_HOLD = 1'b1} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/reg_write_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick of the first requester at or after ptr
module rr_picker
  import reg_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int GW = clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [GW-1:0]   i_ptr,
  output logic [GW-1:0]   o_g,
  output logic            o_valid
);
  logic [GW-1:0] w_idx;
  always_comb begin
    o_g = '0;
    o_valid = 1'b0;
    w_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = GW'((int'(i_ptr) + k) % NREQ);
      if (i_req[w_idx]) begin
        o_g = w_idx;
        o_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin shared register with a guaranteed hold window after each load
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int N = 16,
  parameter int NREQ = 4,
  parameter int HOLD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*N-1:0]        din,
  output logic [NREQ-1:0]          ack,
  output logic [N-1:0]             out,
  output logic [clog2(NREQ)-1:0]   owner,
  output logic                     busy
);
  localparam int GW = clog2(NREQ);
  localparam int CW = clog2(HOLD + 1);
  state_t r_state, w_state_nxt;
  logic [GW-1:0] r_ptr, r_owner, w_g;
  logic [CW-1:0] r_cnt;
  logic [NREQ-1:0] r_ack;
  logic [N-1:0] r_out;
  logic w_valid, w_grant;
  rr_picker #(.NREQ(NREQ), .GW(GW)) u_pick (
    .i_req(req), .i_ptr(r_ptr), .o_g(w_g), .o_valid(w_valid)
  );
  assign w_grant = (r_state == ST_IDLE) && w_valid;
  always_comb begin
    w_state_nxt = (r_state == ST_IDLE) ? (w_valid ? ST_HOLD : ST_IDLE)
                                       : ((r_cnt == '0) ? ST_IDLE : ST_HOLD);
  end
  always_ff @(posedge clk) begin
    r_state <= rst ? ST_IDLE : w_state_nxt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out <= '0;
      r_owner <= '0;
      r_ack <= '0;
      r_ptr <= '0;
      r_cnt <= '0;
    end else begin
      r_ack <= w_grant ? (NREQ'(1) << w_g) : '0;
      if (w_grant) begin
        r_out <= din[int'(w_g)*N +: N];
        r_owner <= w_g;
        r_ptr <= (w_g == GW'(NREQ - 1)) ? '0 : w_g + GW'(1);
        r_cnt <= CW'(HOLD - 1);
      end else if (r_state == ST_HOLD && r_cnt != '0) begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end
  assign ack = r_ack;
  assign out = r_out;
  assign owner = r_owner;
  assign busy = (r_state == ST_HOLD);
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: randomized scoreboard bench against a grant-spacing reference model
module tb_reg_write_arbiter;
  localparam int N = 16, NREQ = 4, HOLD = 2;
  logic clk = 1'b0;
  logic rst;
  logic [NREQ-1:0] req, ack, sticky;
  logic [NREQ*N-1:0] din;
  logic [N-1:0] out;
  logic [1:0] owner;
  logic busy;
  int checks = 0, errors = 0;
  int exp_q[$];
  int m_ptr = 0, m_hold = 0, m_owner = 0;
  int m_out = 0;
  bit mon_en = 0;
  reg_write_arbiter #(.N(N), .NREQ(NREQ), .HOLD(HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .din(din),
    .ack(ack), .out(out), .owner(owner), .busy(busy)
  );
  always #10 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  // Reference: a grant freezes the arbiter for the next HOLD edges; otherwise pick from ptr.
  always @(posedge clk) begin
    if (rst) begin
      m_ptr = 0; m_hold = 0; m_out = 0; m_owner = 0;
      exp_q.delete();
    end else if (m_hold > 0) begin
      m_hold--;
    end else if (req != 0) begin
      int g;
      g = -1;
      for (int k = 0; k < NREQ; k++)
        if (g < 0 && req[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
      exp_q.push_back(g);
      m_out = int'(din[g*N +: N]);
      m_owner = g;
      m_ptr = (g + 1) % NREQ;
      m_hold = HOLD;
    end
  end
  always @(negedge clk) begin
    if (mon_en) begin
      chk("out", int'(out), m_out);
      chk("owner", int'(owner), m_owner);
      chk("busy", int'(busy), int'(m_hold > 0));
      if (ack != 0 || exp_q.size() > 0) begin
        if (exp_q.size() == 0) chk("ack_spurious", int'(ack), 0);
        else chk("ack", int'(ack), 1 << exp_q.pop_front());
      end
    end
  end
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < NREQ; i++)
      if (ack[i] && !sticky[i]) req[i] = 1'b0;
  endtask
  task automatic run(input int n);
    repeat (n) step();
  endtask
  initial begin
    rst = 1'b1; req = '0; din = '0; sticky = '0;
    @(negedge clk);
    @(negedge clk);
    mon_en = 1;
    step();
    rst = 1'b0;
    din[1*N +: N] = 16'd2000; req = 4'b0010;
    run(8);
    din = {16'd1111, 16'd5757, 16'd2564, 16'd2000}; req = 4'b1111;
    run(16);
    sticky = 4'b0101; req = 4'b0101;
    run(20);
    sticky = '0; req = '0;
    run(6);
    din[3*N +: N] = 16'd33; req = 4'b1000;
    run(5);
    req = 4'b1001;
    run(8);
    din[2*N +: N] = 16'd2341; req = 4'b0100;
    step();
    step();
    req = 4'b1010; rst = 1'b1;
    step();
    rst = 1'b0;
    run(12);
    req = 4'b0001;
    step();
    step();
    req[3] = 1'b1;
    step();
    req[3] = 1'b0;
    run(6);
    for (int c = 0; c < 3000; c++) begin
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && $urandom_range(0, 3) == 0) begin
          din[i*N +: N] = N'($urandom);
          req[i] = 1'b1;
        end else if (req[i] && !ack[i] && $urandom_range(0, 31) == 0) begin
          req[i] = 1'b0;
        end
      end
      rst = ($urandom_range(0, 99) == 0);
    end
    rst = 1'b0; req = '0;
    run(8);
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
